// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Entry widths here fix the default address/data widths of the fetch unit.
package if_pkg;

  localparam int IF_ADDR_W = 32;
  localparam int IF_DATA_W = 32;

  localparam logic [IF_DATA_W-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] addr;
    logic [IF_DATA_W-1:0] data;
    logic                 err;
  } fetch_entry_t;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus and decode handshake seen by the fetch unit.
// master = fetch unit side, slave = memory + decode side.
interface if_fetch_unit_if
  import if_pkg::*;
#(
  parameter int ADDR_WIDTH = IF_ADDR_W,
  parameter int DATA_WIDTH = IF_DATA_W
) ();

  logic                  imem_req_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic                  imem_gnt_i;
  logic                  imem_rvalid_i;
  logic [DATA_WIDTH-1:0] imem_rdata_i;
  logic                  imem_err_i;

  logic                  inst_valid_o;
  logic [DATA_WIDTH-1:0] inst_o;
  logic [ADDR_WIDTH-1:0] inst_addr_o;
  logic                  inst_err_o;
  logic                  inst_ready_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
    output inst_valid_o, inst_o, inst_addr_o, inst_err_o,
    input  inst_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i,
    input  inst_valid_o, inst_o, inst_addr_o, inst_err_o,
    output inst_ready_i
  );

endinterface

// File: rtl/if_fetch_unit_sync_fifo.sv
// Synchronous FIFO with any depth >= 2; clear has priority over push/pop.
// Head entry is read combinationally from registered storage.
module sync_fifo
  import if_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CNT_W = cnt_width(DEPTH),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count alone decides which words are live.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues PC fetches, buffers responses with their PCs,
// hands them to decode, holds the PC when not granted and squashes fetches on a jump.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int ADDR_WIDTH = IF_ADDR_W,
  parameter int DATA_WIDTH = IF_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] pc_addr_i,
  input  logic                  flush_i,
  output logic                  fetch_hold_o,
  if_fetch_unit_if.master       bus
);

  localparam int CNT_W   = cnt_width(2 * FIFO_DEPTH);
  localparam int FCNT_W  = cnt_width(FIFO_DEPTH);
  localparam int ENTRY_W = $bits(fetch_entry_t);
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

  logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]      discard_cnt_q, discard_cnt_d;
  logic [CNT_W:0]        in_flight;
  logic                  credit_ok, grant, rsp_keep, rsp_drop, inst_pop;

  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [FCNT_W-1:0]     pend_cnt, inst_cnt;
  logic                  pend_full, pend_empty, inst_full, inst_empty;
  fetch_entry_t          push_entry, head_entry;
  logic [ENTRY_W-1:0]    head_bits;

  always_comb begin
    inst_pop  = !inst_empty && bus.inst_ready_i;
    in_flight = {1'b0, out_cnt_q} + (CNT_W + 1)'(inst_cnt) - (CNT_W + 1)'(inst_pop);
    credit_ok = (in_flight < CREDIT_MAX);

    bus.imem_req_o  = credit_ok && !flush_i;
    bus.imem_addr_o = pc_addr_i;
    grant           = bus.imem_req_o && bus.imem_gnt_i;
    // A jump always wins at the PC register, even when this cycle's fetch is refused.
    fetch_hold_o    = !flush_i && !grant;

    rsp_keep = bus.imem_rvalid_i && (discard_cnt_q == '0);
    rsp_drop = bus.imem_rvalid_i && (discard_cnt_q != '0);

    push_entry = '{addr: pend_addr, data: bus.imem_rdata_i, err: bus.imem_err_i};
    head_entry = fetch_entry_t'(head_bits);

    bus.inst_valid_o = !inst_empty;
    bus.inst_o       = inst_empty ? '0 : head_entry.data;
    bus.inst_addr_o  = inst_empty ? '0 : head_entry.addr;
    bus.inst_err_o   = !inst_empty && head_entry.err;
  end

  always_comb begin
    out_cnt_d     = out_cnt_q;
    discard_cnt_d = discard_cnt_q;
    if (flush_i) begin
      // All live fetches become discards; a response this cycle retires the oldest of them.
      out_cnt_d     = '0;
      discard_cnt_d = discard_cnt_q + out_cnt_q - CNT_W'(bus.imem_rvalid_i);
    end else begin
      out_cnt_d     = out_cnt_q + CNT_W'(grant) - CNT_W'(rsp_keep);
      discard_cnt_d = discard_cnt_q - CNT_W'(rsp_drop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt_q     <= '0;
      discard_cnt_q <= '0;
    end else begin
      out_cnt_q     <= out_cnt_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_pend_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (grant),
    .din_i   (pc_addr_i),
    .pop_i   (rsp_keep),
    .dout_o  (pend_addr),
    .full_o  (pend_full),
    .empty_o (pend_empty),
    .count_o (pend_cnt)
  );

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (rsp_keep),
    .din_i   (push_entry),
    .pop_i   (inst_pop),
    .dout_o  (head_bits),
    .full_o  (inst_full),
    .empty_o (inst_empty),
    .count_o (inst_cnt)
  );

  a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.imem_rvalid_i |-> (out_cnt_q != '0 || discard_cnt_q != '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_keep |-> (flush_i || !inst_full || inst_pop));
  a_pend_consistent: assert property (@(posedge clk_i) disable iff (rst_i)
    (CNT_W'(pend_cnt) == out_cnt_q) && !(grant && pend_full) && !(rsp_keep && pend_empty));

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly downstream of the PC register. Takes the current PC and issues word fetches on the instruction-memory request/grant/response bus. Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. Drives a hold request back to the PC register whenever the current PC is not accepted, and squashes in-flight fetches on a jump.

Parameters:
ADDR_WIDTH, 32, PC and memory address width
DATA_WIDTH, 32, instruction word width
FIFO_DEPTH, 2, instruction buffer entries; also the maximum number of outstanding plus buffered fetches (credit limit), minimum 2

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
pc_addr_i  input  ADDR_WIDTH  current PC from the PC register
flush_i  input  1  jump taken this cycle; same cycle the PC register loads the jump target
fetch_hold_o  output  1  to PC register hold input; 1 = keep PC this cycle
imem_req_o  output  1  fetch request valid
imem_addr_o  output  ADDR_WIDTH  fetch address, equals pc_addr_i
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response valid, in order, latency of 1 or more cycles after grant
imem_rdata_i  input  DATA_WIDTH  response instruction
imem_err_i  input  1  bus error, qualified by imem_rvalid_i
inst_valid_o  output  1  instruction available to decode
inst_o  output  DATA_WIDTH  instruction
inst_addr_o  output  ADDR_WIDTH  PC of inst_o
inst_err_o  output  1  fetch error flag for inst_o
inst_ready_i  input  1  decode accepts the entry when inst_valid_o && inst_ready_i

Behaviour:
- Reset: all counters 0, both FIFOs empty. inst_valid_o=0, inst_o/inst_addr_o/inst_err_o=0. Combinational outputs follow their equations with empty state: imem_req_o=1, fetch_hold_o=!imem_gnt_i.
- pop = inst_valid_o && inst_ready_i.
- credit_ok = (out_cnt + fifo_cnt - pop) < FIFO_DEPTH. out_cnt counts granted, not-yet-returned, non-discarded fetches.
- imem_req_o = credit_ok && !flush_i. imem_addr_o = pc_addr_i, combinational.
- fetch_hold_o = !flush_i && !(imem_req_o && imem_gnt_i). The PC advances only on grant. On flush the hold is always 0, so the jump wins in the PC register.
- On grant: push pc_addr_i into the pending-address FIFO (depth FIFO_DEPTH); out_cnt+1.
- On imem_rvalid_i with discard_cnt==0: pop the pending address and push {addr, rdata, err} into the instruction FIFO; out_cnt-1. inst_valid_o rises the cycle after rvalid (registered, no bypass).
- On imem_rvalid_i with discard_cnt>0: drop the response, discard_cnt-1, no FIFO activity.
- The credit rule guarantees the instruction FIFO never overflows. A response arriving while the FIFO would overflow is a protocol violation (assertion).
- flush_i (highest priority, overrides same-cycle pop and push): clear both FIFOs. Set discard_cnt = discard_cnt + out_cnt - (imem_rvalid_i && discard_cnt==0 ? 1 : 0), or discard_cnt - 1 if imem_rvalid_i && discard_cnt>0. Set out_cnt=0. inst_valid_o=0 the next cycle.
- New fetches may issue while discard_cnt>0. Responses are in order, so discards are always the oldest.
- Counter width $clog2(2*FIFO_DEPTH+1); never wraps.
- Throughput: 1 instruction/cycle at memory latency 1 with decode always ready.
- Reset mid-operation: state cleared next edge; later stray rvalids are treated as discards only if discard_cnt>0, otherwise assertion.

Decomposition:
- Package if_pkg: fetch_entry_t struct {addr, data, err}; INST_NOP constant (32'h00000013).
- Sub-module sync_fifo (parameterised width/depth, push/pop/clear, full/empty/count), instantiated twice: pending-address FIFO and instruction FIFO.

Test Plan:
- Reset, memory always grants, latency 1, decode ready, PC stepping 0,4,8 -> after first response inst_valid_o stays 1 every cycle, inst_addr_o=0,4,8,12 in order, fetch_hold_o=0.
- imem_gnt_i=0 for 3 cycles at PC 0x10 -> fetch_hold_o=1 for those 3 cycles, imem_addr_o stays 0x10, one fetch recorded on grant.
- inst_ready_i=0 with latency 1 -> at most 2 entries buffered, imem_req_o drops to 0, no overflow; on ready, entries 0x0 then 0x4 drain in order.
- Two fetches outstanding (latency 3), flush_i pulse -> discard_cnt=2, both responses dropped, first delivered inst_addr_o equals the jump target, fetch_hold_o=0 in the flush cycle.
- flush_i coincident with imem_rvalid_i and one more outstanding -> that response dropped, discard_cnt=1, next response dropped, inst_valid_o=0 the cycle after flush.
- Response with imem_err_i=1 at PC 0x20 -> inst_err_o=1 with inst_addr_o=0x20; rst_i asserted mid-stream -> inst_valid_o=0 next cycle, counters 0.
